// File: rtl/dwb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dwb_pkg
// Purpose  : Default widths, slot record and same-address commit resolution
//            shared by the deferred write bank.
// Revision : 1.0
// ============================================================================
package dwb_pkg;

    localparam int c_data_w  = 16;
    localparam int c_addr_w  = 2;
    localparam int c_depth   = 4;
    localparam int c_delay_w = 6;
    // One bit wider than the delay: two coexisting slots are never more than
    // 2**c_delay_w - 1 acceptances apart, so a wrapped difference still orders them.
    localparam int c_age_w   = c_delay_w + 1;

    typedef struct packed {
        logic                 valid;
        logic [c_addr_w-1:0]  addr;
        logic [c_data_w-1:0]  data;
        logic [c_delay_w-1:0] countdown;
        logic [c_age_w-1:0]   age;
    } slot_t;

    function automatic logic [c_depth-1:0] youngest_wins(
        input logic [c_depth-1:0]               expire,
        input logic [c_depth-1:0][c_addr_w-1:0] addr,
        input logic [c_depth-1:0][c_age_w-1:0]  age
    );
        logic [c_depth-1:0] win;
        logic [c_age_w-1:0] diff;
        for (int i = 0; i < c_depth; i++) begin
            win[i] = expire[i];
            for (int j = 0; j < c_depth; j++) begin
                diff = age[j] - age[i];
                if ((j != i) && expire[j] && (addr[j] == addr[i]) &&
                    !diff[c_age_w-1] && (diff != '0)) begin
                    win[i] = 1'b0;
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwb_slot.sv
`default_nettype none
// ============================================================================
// Module   : dwb_slot
// Purpose  : One pending write entry: load, count down, expire and self-clear.
// Revision : 1.0
// ============================================================================
module dwb_slot
    import dwb_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [c_addr_w-1:0]  load_addr,
    input  logic [c_data_w-1:0]  load_data,
    input  logic [c_delay_w-1:0] load_delay,
    input  logic [c_age_w-1:0]   load_age,
    output logic                 valid,
    output logic [c_addr_w-1:0]  addr,
    output logic [c_data_w-1:0]  data,
    output logic [c_age_w-1:0]   age,
    output logic                 expire
);

    slot_t r_slot;

    // Load is only issued to a free slot, so it never collides with expiry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_slot <= '0;
        end else if (load) begin
            r_slot <= '{valid: 1'b1, addr: load_addr, data: load_data,
                        countdown: load_delay, age: load_age};
        end else if (expire) begin
            r_slot.valid <= 1'b0;
        end else if (r_slot.valid && (r_slot.countdown != '0)) begin
            r_slot.countdown <= r_slot.countdown - c_delay_w'(1);
        end
    end

    assign expire = r_slot.valid && (r_slot.countdown == '0);
    assign valid  = r_slot.valid;
    assign addr   = r_slot.addr;
    assign data   = r_slot.data;
    assign age    = r_slot.age;

endmodule
`default_nettype wire

// File: rtl/deferred_write_bank.sv
`default_nettype none
// ============================================================================
// Module   : deferred_write_bank
// Purpose  : Register bank committing each write a programmable number of
//            cycles after acceptance. Optional register exchange: SWAP_EN.
// Revision : 1.0
// ============================================================================
module deferred_write_bank
    import dwb_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int ADDR_W  = c_addr_w,
    parameter int DEPTH   = c_depth,
    parameter int DELAY_W = c_delay_w
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DELAY_W-1:0]         wr_delay,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
`ifdef SWAP_EN
    input  logic                       swap_req,
    input  logic [ADDR_W-1:0]          swap_a,
    input  logic [ADDR_W-1:0]          swap_b,
`endif
    output logic [(2**ADDR_W)-1:0]     commit_mask,
    output logic [$clog2(DEPTH+1)-1:0] pending_count
);

    localparam int c_nreg  = 2**ADDR_W;
    localparam int c_cnt_w = $clog2(DEPTH+1);

    // Slot records are sized by the package; overriding widths is not supported.
    if ((DATA_W != c_data_w) || (ADDR_W != c_addr_w) ||
        (DEPTH != c_depth) || (DELAY_W != c_delay_w)) begin : g_param_check
        $error("deferred_write_bank: parameters must equal the dwb_pkg widths");
    end

    logic [DEPTH-1:0]              w_valid;
    logic [DEPTH-1:0]              w_expire;
    logic [DEPTH-1:0]              w_load_oh;
    logic [DEPTH-1:0]              w_win;
    logic [DEPTH-1:0][ADDR_W-1:0]  w_addr;
    logic [DEPTH-1:0][DATA_W-1:0]  w_data;
    logic [DEPTH-1:0][c_age_w-1:0] w_age;
    logic [c_age_w-1:0]            r_age_ctr;
    logic                          w_accept;
    logic [DATA_W-1:0]             r_bank      [c_nreg];
    logic [DATA_W-1:0]             w_bank_next [c_nreg];
    logic [DATA_W-1:0]             r_rd_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        dwb_slot u_slot (
            .clock      (clock),
            .reset_n    (reset_n),
            .load       (w_load_oh[i]),
            .load_addr  (wr_addr),
            .load_data  (wr_data),
            .load_delay (wr_delay),
            .load_age   (r_age_ctr),
            .valid      (w_valid[i]),
            .addr       (w_addr[i]),
            .data       (w_data[i]),
            .age        (w_age[i]),
            .expire     (w_expire[i])
        );
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_count = pending_count + c_cnt_w'(w_valid[i]);
        end
    end

    assign wr_ready = (pending_count < c_cnt_w'(DEPTH));
    assign w_accept = wr_valid && wr_ready;

    // Scanning downward leaves only the lowest free slot selected.
    always_comb begin
        w_load_oh = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_load_oh    = '0;
                w_load_oh[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_age_ctr <= '0;
        end else if (w_accept) begin
            r_age_ctr <= r_age_ctr + c_age_w'(1);
        end
    end

    assign w_win = youngest_wins(w_expire, w_addr, w_age);

    always_comb begin
        commit_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_expire[i] && reset_n) begin
                commit_mask[w_addr[i]] = 1'b1;
            end
        end
    end

    // Swap uses pre-edge values; commits are applied afterwards and take priority.
    always_comb begin
        for (int r = 0; r < c_nreg; r++) begin
            w_bank_next[r] = r_bank[r];
        end
`ifdef SWAP_EN
        if (swap_req) begin
            w_bank_next[swap_a] = r_bank[swap_b];
            w_bank_next[swap_b] = r_bank[swap_a];
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (w_win[i]) begin
                w_bank_next[w_addr[i]] = w_data[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < c_nreg; r++) begin
                r_bank[r] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            for (int r = 0; r < c_nreg; r++) begin
                r_bank[r] <= w_bank_next[r];
            end
            r_rd_data <= r_bank[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_deferred_write_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_deferred_write_bank
// Purpose  : Directed, scoreboard-checked bench for deferred_write_bank.
// Revision : 1.0
// ============================================================================
module tb_deferred_write_bank;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 2;
    localparam int DEPTH   = 4;
    localparam int DELAY_W = 6;

    logic                clock    = 1'b0;
    logic                reset_n  = 1'b0;
    logic                wr_valid = 1'b0;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr  = '0;
    logic [DATA_W-1:0]   wr_data  = '0;
    logic [DELAY_W-1:0]  wr_delay = '0;
    logic [ADDR_W-1:0]   rd_addr  = '0;
    logic [DATA_W-1:0]   rd_data;
    logic [3:0]          commit_mask;
    logic [2:0]          pending_count;
`ifdef SWAP_EN
    logic                swap_req = 1'b0;
    logic [ADDR_W-1:0]   swap_a   = '0;
    logic [ADDR_W-1:0]   swap_b   = '0;
`endif

    always #5 clock = ~clock;

    deferred_write_bank #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .DELAY_W (DELAY_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_delay      (wr_delay),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
`ifdef SWAP_EN
        .swap_req      (swap_req),
        .swap_a        (swap_a),
        .swap_b        (swap_b),
`endif
        .commit_mask   (commit_mask),
        .pending_count (pending_count)
    );

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sbq[$];
    logic [DATA_W-1:0] mbank [4];
    logic [DATA_W-1:0] exp_rd;
    int                ecount = 0;
    bit                acc_seen = 1'b0;
    int                dut_acc_edge = 0;
    int                checks = 0;
    int                errors = 0;

    // Transaction model: each accepted write is due at the edge after its delay expires.
    always @(posedge clock) begin : model
        bit                model_ready;
        exp_t              keep[$];
        logic [DATA_W-1:0] tmp;
        ecount++;
        if (!reset_n) begin
            sbq.delete();
            foreach (mbank[r]) mbank[r] = '0;
            exp_rd = '0;
        end else begin
            model_ready = (sbq.size() < DEPTH);
            exp_rd = mbank[rd_addr];
`ifdef SWAP_EN
            if (swap_req) begin
                tmp = mbank[swap_a];
                mbank[swap_a] = mbank[swap_b];
                mbank[swap_b] = tmp;
            end
`endif
            tmp = '0;
            keep.delete();
            foreach (sbq[i]) begin
                if (sbq[i].due == ecount) mbank[sbq[i].addr] = sbq[i].data;
                else keep.push_back(sbq[i]);
            end
            sbq = keep;
            if (wr_valid && model_ready) begin
                sbq.push_back('{due: ecount + int'(wr_delay) + 1, addr: wr_addr, data: wr_data});
                acc_seen = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [3:0] m;
        m = '0;
        foreach (sbq[i]) if (sbq[i].due == ecount + 1) m[sbq[i].addr] = 1'b1;
        chk("rd_data", 32'(rd_data), 32'(exp_rd));
        chk("pending_count", 32'(pending_count), 32'(sbq.size()));
        chk("wr_ready", 32'(wr_ready), 32'(sbq.size() < DEPTH));
        chk("commit_mask", 32'(commit_mask), 32'(m));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        check_cycle();
    endtask

    // Holds wr_valid until the model accepts; records the edge the DUT accepted at.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DELAY_W-1:0] dl);
        bit dut_rdy;
        bit dut_took;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_delay = dl;
        acc_seen = 1'b0;
        dut_took = 1'b0;
        for (int n = 0; n < 40 && !acc_seen; n++) begin
            dut_rdy = wr_ready;
            tick();
            if (dut_rdy && !dut_took) begin
                dut_took     = 1'b1;
                dut_acc_edge = ecount;
            end
        end
        wr_valid = 1'b0;
        chk("write_accepted", 32'(dut_took), 32'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t5;

        // Reset
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr = ADDR_W'(a);
            tick();
            chk("reset_rd", 32'(rd_data), 32'(0));
        end
        chk("reset_pending", 32'(pending_count), 32'(0));
        chk("reset_ready", 32'(wr_ready), 32'(1));
        chk("reset_mask", 32'(commit_mask), 32'(0));

        // Single delayed write
        rd_addr = 2;
        do_write(2, 16'hBEEF, 3);
        tick();
        tick();
        chk("single_mask_pre", 32'(commit_mask), 32'(0));
        tick();
        chk("single_mask", 32'(commit_mask), 32'(4'b0100));
        tick();
        chk("single_rd_old", 32'(rd_data), 32'(0));
        chk("single_mask_post", 32'(commit_mask), 32'(0));
        tick();
        chk("single_rd_new", 32'(rd_data), 32'(16'hBEEF));

        // Same-address collision
        rd_addr = 1;
        do_write(1, 16'h1111, 4);
        do_write(1, 16'h2222, 3);
        chk("coll_pending2", 32'(pending_count), 32'(2));
        tick();
        tick();
        tick();
        chk("coll_mask", 32'(commit_mask), 32'(4'b0010));
        chk("coll_pending_pre", 32'(pending_count), 32'(2));
        tick();
        chk("coll_pending0", 32'(pending_count), 32'(0));
        tick();
        chk("coll_rd", 32'(rd_data), 32'(16'h2222));

        // Full backpressure
        do_write(0, 16'h0001, 10);
        t0 = dut_acc_edge;
        do_write(1, 16'h0002, 10);
        do_write(2, 16'h0003, 10);
        do_write(3, 16'h0004, 10);
        chk("bp_pending4", 32'(pending_count), 32'(4));
        chk("bp_ready0", 32'(wr_ready), 32'(0));
        rd_addr = 3;
        do_write(3, 16'h0005, 10);
        t5 = dut_acc_edge;
        chk("bp_fifth_edge", 32'(t5), 32'(t0 + 12));
        repeat (10) tick();
        chk("bp_fifth_mask", 32'(commit_mask), 32'(4'b1000));
        tick();
        tick();
        chk("bp_fifth_rd", 32'(rd_data), 32'(16'h0005));

        // Reset during operation
        rd_addr = 0;
        do_write(0, 16'h1234, 5);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("rst_op_rd", 32'(rd_data), 32'(0));
        chk("rst_op_pending", 32'(pending_count), 32'(0));

`ifdef SWAP_EN
        do_write(0, 16'h000A, 0);
        do_write(3, 16'h000B, 0);
        tick();
        tick();
        swap_a   = 0;
        swap_b   = 3;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        rd_addr  = 0;
        tick();
        chk("swap_rd0", 32'(rd_data), 32'(16'h000B));
        rd_addr = 3;
        tick();
        chk("swap_rd3", 32'(rd_data), 32'(16'h000A));

        do_write(0, 16'h000A, 0);
        do_write(3, 16'h000B, 0);
        tick();
        tick();
        do_write(3, 16'h00C3, 0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        rd_addr  = 3;
        tick();
        chk("swapc_rd3", 32'(rd_data), 32'(16'h00C3));
        rd_addr = 0;
        tick();
        chk("swapc_rd0", 32'(rd_data), 32'(16'h000B));
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
